// File: rtl/speicher_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and data port.
// Latency: request sampled in IDLE -> strobe next cycle -> done pulse 2+L cycles after request.
// Backpressure: requests are level-held; the FERTIG turnaround cycle forces a re-sample before the next grant.
module speicher_arbiter #(
    parameter int ADRESSBREITE = 8,
    parameter int WORTBREITE   = 32,
    parameter int TIMEOUT      = 64
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    LeseInstruktion,
    input  logic [31:0]             InstruktionAdresse,
    output logic [WORTBREITE-1:0]   Instruktion,
    output logic                    InstruktionGeladen,
    input  logic                    LeseDaten,
    input  logic                    SchreibeDaten,
    input  logic [31:0]             DatenAdresse,
    input  logic [WORTBREITE-1:0]   DatenRaus,
    output logic [WORTBREITE-1:0]   DatenRein,
    output logic                    DatenGeladen,
    output logic                    DatenGespeichert,
    output logic                    RAMLesenAn,
    output logic                    RAMSchreibenAn,
    output logic [ADRESSBREITE-1:0] RAMAdresse,
    output logic [WORTBREITE-1:0]   RAMDatenSchreiben,
    input  logic [WORTBREITE-1:0]   RAMDatenLesen,
    input  logic                    RAMDatenBereit,
    input  logic                    RAMDatenGeschrieben,
    output logic                    Fehler
);

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        D_LESEN,
        D_SCHREIBEN,
        FERTIG
    } zustand_t;

    localparam int ZW = $clog2(TIMEOUT + 1);

    zustand_t        zustand;
    zustand_t        folgeZustand;
    zustand_t        auftrag;
    logic            letzter;
    logic [ZW-1:0]   waechter;
    logic            datenAnfrage;
    logic            waehleInstr;
    logic            waehleDaten;
    logic            ramFertig;
    logic            abbruch;
    logic            imZugriff;
    logic            unusedAdressBits;

    assign unusedAdressBits = ^{InstruktionAdresse[31:ADRESSBREITE], DatenAdresse[31:ADRESSBREITE]};

    // letzter = 1 means the data port was served last
    assign datenAnfrage = LeseDaten | SchreibeDaten;
    assign waehleInstr  = LeseInstruktion && (!datenAnfrage || letzter);
    assign waehleDaten  = datenAnfrage && (!LeseInstruktion || !letzter);

    assign imZugriff = (zustand == INSTR) || (zustand == D_LESEN) || (zustand == D_SCHREIBEN);
    assign ramFertig = ((zustand == INSTR) || (zustand == D_LESEN)) ? RAMDatenBereit :
                       (zustand == D_SCHREIBEN) ? RAMDatenGeschrieben : 1'b0;
    assign abbruch   = imZugriff && !ramFertig && (waechter == ZW'(TIMEOUT));

    assign RAMLesenAn         = (zustand == INSTR) || (zustand == D_LESEN);
    assign RAMSchreibenAn     = (zustand == D_SCHREIBEN);
    assign InstruktionGeladen = (zustand == FERTIG) && (auftrag == INSTR);
    assign DatenGeladen       = (zustand == FERTIG) && (auftrag == D_LESEN);
    assign DatenGespeichert   = (zustand == FERTIG) && (auftrag == D_SCHREIBEN);

    always_comb begin
        folgeZustand = zustand;
        case (zustand)
            IDLE: begin
                if (waehleInstr) begin
                    folgeZustand = INSTR;
                end else if (waehleDaten) begin
                    folgeZustand = SchreibeDaten ? D_SCHREIBEN : D_LESEN;
                end
            end
            INSTR, D_LESEN, D_SCHREIBEN: begin
                if (ramFertig || abbruch) begin
                    folgeZustand = FERTIG;
                end
            end
            FERTIG:  folgeZustand = IDLE;
            default: folgeZustand = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand           <= IDLE;
            auftrag           <= IDLE;
            letzter           <= 1'b1;
            waechter          <= '0;
            RAMAdresse        <= '0;
            RAMDatenSchreiben <= '0;
            Instruktion       <= '0;
            DatenRein         <= '0;
            Fehler            <= 1'b0;
        end else begin
            zustand <= folgeZustand;
            if (zustand == IDLE) begin
                if (waehleInstr) begin
                    RAMAdresse <= InstruktionAdresse[ADRESSBREITE-1:0];
                    auftrag    <= INSTR;
                    letzter    <= 1'b0;
                    waechter   <= '0;
                end else if (waehleDaten) begin
                    RAMAdresse <= DatenAdresse[ADRESSBREITE-1:0];
                    if (SchreibeDaten) begin
                        RAMDatenSchreiben <= DatenRaus;
                        auftrag           <= D_SCHREIBEN;
                    end else begin
                        auftrag <= D_LESEN;
                    end
                    letzter  <= 1'b1;
                    waechter <= '0;
                end
            end
            if (imZugriff) begin
                waechter <= waechter + ZW'(1);
                // an aborted read leaves zero in the port's data register
                if (ramFertig || abbruch) begin
                    if (zustand == INSTR) begin
                        Instruktion <= ramFertig ? RAMDatenLesen : '0;
                    end else if (zustand == D_LESEN) begin
                        DatenRein <= ramFertig ? RAMDatenLesen : '0;
                    end
                end
                if (abbruch) begin
                    Fehler <= 1'b1;
                end
            end
        end
    end

endmodule
